// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC step -> address latch -> memory read -> IR hold for decoder; jump/branch redirects load PC.
// Latency: 2 cycles from PCRD to mem_rd_req; IR presented the cycle after mem ack. Backpressure: ir_ready low holds IR, no new fetch.
// Optional macro BRANCH_IMM_EN: opcode BR_OPCODE words redirect the PC via BRIMM instead of reaching the decoder.
module fetch_ctrl #(
    parameter int ADDR_W                = 8,
`ifdef BRANCH_IMM_EN
    parameter logic [3:0] BR_OPCODE     = 4'hF,
`endif
    parameter int INSTR_W               = 16,
    parameter logic [3:0] MEM_TIMEOUT   = 4'd15
) (
    input  logic               fetch_clk,
    input  logic               fetch_rst_n,
    input  logic               fetch_halt,
    input  logic [ADDR_W-1:0]  pc_count_out,
    output logic               pc_rd_en,
    output logic               pc_count,
    output logic               pc_dir,
    output logic               pc_wr_en,
    output logic [ADDR_W-1:0]  pc_count_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_req,
    input  logic               mem_rd_ack,
    input  logic [INSTR_W-1:0] mem_rd_data,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               fetch_err
);

`ifdef BRANCH_IMM_EN
    typedef enum logic [2:0] {IDLE, PCRD, PCLAT, MEMRD, HOLD, BRIMM, JUMP} state_t;
`else
    typedef enum logic [2:0] {IDLE, PCRD, PCLAT, MEMRD, HOLD, JUMP} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
    logic                jump_pend_q, jump_pend_d;
    logic [3:0]          tmo_cnt_q, tmo_cnt_d;
    logic                err_q, err_d;

    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ir_q        <= '0;
            jaddr_q     <= '0;
            jump_pend_q <= 1'b0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            jaddr_q     <= jaddr_d;
            jump_pend_q <= jump_pend_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
        end
    end

    // A new pulse always wins over the clear in JUMP so back-to-back jumps are not lost.
    always_comb begin
        jump_pend_d = jump_pend_q;
        jaddr_d     = jaddr_q;
        if (jump_req) begin
            jump_pend_d = 1'b1;
            jaddr_d     = jump_addr;
        end else if (state_q == JUMP) begin
            jump_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (jump_pend_q)      state_d = JUMP;
                else if (!fetch_halt) state_d = PCRD;
            end
            PCRD:  state_d = jump_pend_q ? JUMP : PCLAT;
            PCLAT: begin
                addr_d    = pc_count_out;
                tmo_cnt_d = '0;
                state_d   = jump_pend_q ? JUMP : MEMRD;
            end
            MEMRD: begin
                if (mem_rd_ack) begin
                    if (jump_pend_q) begin
                        state_d = JUMP;
                    end else begin
                        ir_d    = mem_rd_data;
`ifdef BRANCH_IMM_EN
                        state_d = (mem_rd_data[INSTR_W-1 -: 4] == BR_OPCODE) ? BRIMM : HOLD;
`else
                        state_d = HOLD;
`endif
                    end
                end else if (tmo_cnt_q == MEM_TIMEOUT - 4'd1) begin
                    // PC was not stepped, so PCLAT re-latches the same address for the retry.
                    err_d   = 1'b1;
                    state_d = PCLAT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (jump_pend_q)   state_d = JUMP;
                else if (ir_ready) state_d = fetch_halt ? IDLE : PCRD;
            end
`ifdef BRANCH_IMM_EN
            BRIMM: begin
                if (jump_pend_q) state_d = JUMP;
                else             state_d = fetch_halt ? IDLE : PCRD;
            end
`endif
            JUMP: begin
                if (jump_req) state_d = JUMP;
                else          state_d = fetch_halt ? IDLE : PCRD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_count_in = '0;
        if (state_q == JUMP) pc_count_in = jaddr_q;
`ifdef BRANCH_IMM_EN
        else if (state_q == BRIMM) pc_count_in = ir_q[ADDR_W-1:0];
`endif
    end

    assign pc_rd_en   = (state_q == PCRD);
    assign pc_count   = (state_q == PCRD);
    assign pc_dir     = 1'b0;
`ifdef BRANCH_IMM_EN
    assign pc_wr_en   = (state_q == JUMP) || (state_q == BRIMM);
`else
    assign pc_wr_en   = (state_q == JUMP);
`endif
    assign mem_addr   = addr_q;
    assign mem_rd_req = (state_q == MEMRD);
    assign ir_out     = ir_q;
    assign ir_valid   = (state_q == HOLD);
    assign fetch_err  = err_q;

endmodule
